// File: rtl/game_pkg.sv
// Shared screen geometry, FSM state encoding and position type for the game blocks.
package game_pkg;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned PIPE_SPACING = 320;
    localparam int unsigned BIRD_X       = 100;
    localparam int unsigned GAP_MIN      = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef logic [15:0] pos_t;

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs and pipe/score outputs of the pipe scroller.
interface pipe_scroller_if;

    logic        frame_tick;
    logic        start;
    logic        collide;
    logic        restart;
    logic [15:0] PipesPosition1;
    logic [15:0] PipesPosition2;
    logic [9:0]  GapY1;
    logic [9:0]  GapY2;
    logic [7:0]  score;
    logic        score_pulse;
    logic        running;

    modport master (
        output frame_tick, start, collide, restart,
        input  PipesPosition1, PipesPosition2, GapY1, GapY2, score, score_pulse, running
    );

    modport slave (
        input  frame_tick, start, collide, restart,
        output PipesPosition1, PipesPosition2, GapY1, GapY2, score, score_pulse, running
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : '0);
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls two pipe pairs leftward once per frame tick while running, re-rolls gaps on wrap,
// and counts pipes crossing the bird column into a saturating score.
module pipe_scroller
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_W     = game_pkg::SCREEN_W,
    parameter int unsigned PIPE_SPACING = game_pkg::PIPE_SPACING,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned BIRD_X       = game_pkg::BIRD_X,
    parameter int unsigned GAP_MIN      = game_pkg::GAP_MIN,
    parameter logic [7:0]  GAP_MASK     = 8'hFF,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic            clk,
    input logic            rst_n,
    pipe_scroller_if.slave bus
);

    localparam pos_t       POS1_RST = pos_t'(SCREEN_W);
    localparam pos_t       POS2_RST = pos_t'(SCREEN_W + PIPE_SPACING);
    localparam pos_t       SPEED16  = pos_t'(SPEED);
    localparam pos_t       WRAP16   = pos_t'(2 * PIPE_SPACING - SPEED);
    localparam pos_t       BIRD16   = pos_t'(BIRD_X);
    localparam logic [9:0] GAP10    = 10'(GAP_MIN);

    state_t      state;
    logic        running_q;
    logic        score_pulse_q;
    logic [7:0]  score_q;
    logic [7:0]  score_nxt;
    pos_t        pos_q   [2];
    pos_t        pos_nxt [2];
    logic [9:0]  gap_q   [2];
    logic [9:0]  gap_nxt [2];
    logic [1:0]  inc;
    logic [8:0]  score_sum;
    logic [15:0] lfsr;
    logic [7:0]  rnd;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    // Same update for both pipes; pipe 2 draws its gap from the upper LFSR byte.
    always_comb begin
        inc = '0;
        rnd = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            pos_nxt[i] = pos_q[i];
            gap_nxt[i] = gap_q[i];
            rnd        = (i == 0) ? lfsr[7:0] : lfsr[15:8];
            if (pos_q[i] >= SPEED16) begin
                pos_nxt[i] = pos_q[i] - SPEED16;
                if ((pos_q[i] >= BIRD16) && (pos_nxt[i] < BIRD16)) begin
                    inc = inc + 2'd1;
                end
            end else begin
                pos_nxt[i] = pos_q[i] + WRAP16;
                gap_nxt[i] = GAP10 + {2'b00, rnd & GAP_MASK};
            end
        end
        score_sum = {1'b0, score_q} + {7'b0, inc};
        score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            running_q     <= 1'b0;
            score_q       <= '0;
            score_pulse_q <= 1'b0;
            pos_q[0]      <= POS1_RST;
            pos_q[1]      <= POS2_RST;
            gap_q[0]      <= GAP10;
            gap_q[1]      <= GAP10;
        end else begin
            score_pulse_q <= 1'b0;
            if (bus.restart) begin
                state     <= IDLE;
                running_q <= 1'b0;
                score_q   <= '0;
                pos_q[0]  <= POS1_RST;
                pos_q[1]  <= POS2_RST;
                gap_q[0]  <= GAP10;
                gap_q[1]  <= GAP10;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.collide) begin
                            state     <= HALT;
                            running_q <= 1'b0;
                        end else if (bus.frame_tick) begin
                            for (int unsigned i = 0; i < 2; i++) begin
                                pos_q[i] <= pos_nxt[i];
                                gap_q[i] <= gap_nxt[i];
                            end
                            score_q       <= score_nxt;
                            score_pulse_q <= (score_nxt != score_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.PipesPosition1 = pos_q[0];
    assign bus.PipesPosition2 = pos_q[1];
    assign bus.GapY1          = gap_q[0];
    assign bus.GapY2          = gap_q[1];
    assign bus.score          = score_q;
    assign bus.score_pulse    = score_pulse_q;
    assign bus.running        = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller: default instance A plus instance B (SCREEN_W=639) whose pipe 1 reaches 1.
module tb_pipe_scroller;

    logic clk;
    logic rst_n;
    logic frame_tick;
    logic start;
    logic collide;
    logic restart;

    int n_cmp;
    int n_bad;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    pipe_scroller_if ifa ();
    pipe_scroller_if ifb ();

    assign ifa.frame_tick = frame_tick;
    assign ifa.start      = start;
    assign ifa.collide    = collide;
    assign ifa.restart    = restart;
    assign ifb.frame_tick = frame_tick;
    assign ifb.start      = start;
    assign ifb.collide    = collide;
    assign ifb.restart    = restart;

    pipe_scroller dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    pipe_scroller #(.SCREEN_W(639)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value the DUT sampled at the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    task automatic run_ticks(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0; start = 1'b0; collide = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd640) begin n_bad++; $display("FAIL rst_pos1: got %0d want 640", ifa.PipesPosition1); end
        n_cmp++; if (ifa.PipesPosition2 !== 16'd960) begin n_bad++; $display("FAIL rst_pos2: got %0d want 960", ifa.PipesPosition2); end
        n_cmp++; if (ifa.GapY1 !== 10'd80 || ifa.GapY2 !== 10'd80) begin n_bad++; $display("FAIL rst_gap: got %0d/%0d want 80/80", ifa.GapY1, ifa.GapY2); end
        n_cmp++; if (ifa.score !== 8'd0 || ifa.score_pulse !== 1'b0 || ifa.running !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got score %0d pulse %0b run %0b want 0/0/0", ifa.score, ifa.score_pulse, ifa.running); end
        n_cmp++; if (ifb.PipesPosition1 !== 16'd639 || ifb.PipesPosition2 !== 16'd959) begin n_bad++; $display("FAIL rst_b_pos: got %0d/%0d want 639/959", ifb.PipesPosition1, ifb.PipesPosition2); end
    endtask

    task automatic test_run10();
        run_ticks(2);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd640) begin n_bad++; $display("FAIL idle_tick: got %0d want 640", ifa.PipesPosition1); end
        pulse_start();
        n_cmp++; if (ifa.running !== 1'b1) begin n_bad++; $display("FAIL start_run: got %0b want 1", ifa.running); end
        run_ticks(10);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd620 || ifa.PipesPosition2 !== 16'd940) begin n_bad++; $display("FAIL run10_pos: got %0d/%0d want 620/940", ifa.PipesPosition1, ifa.PipesPosition2); end
        n_cmp++; if (ifa.score !== 8'd0 || ifa.running !== 1'b1) begin n_bad++; $display("FAIL run10_flags: got score %0d run %0b want 0/1", ifa.score, ifa.running); end
    endtask

    task automatic test_score_cross();
        run_ticks(259);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd102 || ifa.score !== 8'd0) begin n_bad++; $display("FAIL at102: got pos %0d score %0d want 102/0", ifa.PipesPosition1, ifa.score); end
        run_ticks(1);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd100 || ifa.score !== 8'd0 || ifa.score_pulse !== 1'b0) begin n_bad++; $display("FAIL 102to100: got pos %0d score %0d pulse %0b want 100/0/0", ifa.PipesPosition1, ifa.score, ifa.score_pulse); end
        run_ticks(1);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd98 || ifa.score !== 8'd1 || ifa.score_pulse !== 1'b1) begin n_bad++; $display("FAIL 100to98: got pos %0d score %0d pulse %0b want 98/1/1", ifa.PipesPosition1, ifa.score, ifa.score_pulse); end
        @(negedge clk);
        n_cmp++; if (ifa.score_pulse !== 1'b0 || ifa.score !== 8'd1) begin n_bad++; $display("FAIL pulse_width: got pulse %0b score %0d want 0/1", ifa.score_pulse, ifa.score); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_gap;
        run_ticks(48);
        n_cmp++; if (ifb.PipesPosition1 !== 16'd1) begin n_bad++; $display("FAIL b_at1: got %0d want 1", ifb.PipesPosition1); end
        run_ticks(1);
        exp_gap = 10'd80 + {2'b00, m_prev[7:0]};
        n_cmp++; if (ifb.PipesPosition1 !== 16'd639) begin n_bad++; $display("FAIL b_wrap_pos: got %0d want 639", ifb.PipesPosition1); end
        n_cmp++; if (ifb.GapY1 !== exp_gap) begin n_bad++; $display("FAIL b_wrap_gap: got %0d want %0d", ifb.GapY1, exp_gap); end
        n_cmp++; if (ifb.GapY2 !== 10'd80) begin n_bad++; $display("FAIL b_gap2_hold: got %0d want 80", ifb.GapY2); end
        n_cmp++; if (ifa.PipesPosition1 !== 16'd0) begin n_bad++; $display("FAIL a_at0: got %0d want 0", ifa.PipesPosition1); end
        run_ticks(1);
        exp_gap = 10'd80 + {2'b00, m_prev[7:0]};
        n_cmp++; if (ifa.PipesPosition1 !== 16'd638 || ifa.PipesPosition2 !== 16'd318) begin n_bad++; $display("FAIL a_wrap_pos: got %0d/%0d want 638/318", ifa.PipesPosition1, ifa.PipesPosition2); end
        n_cmp++; if (ifa.GapY1 !== exp_gap) begin n_bad++; $display("FAIL a_wrap_gap: got %0d want %0d", ifa.GapY1, exp_gap); end
        n_cmp++; if (((32'(ifa.PipesPosition2) + 32'd640 - 32'(ifa.PipesPosition1)) % 640) !== 320) begin n_bad++; $display("FAIL spacing: got %0d/%0d want 320 apart mod 640", ifa.PipesPosition1, ifa.PipesPosition2); end
        n_cmp++; if (ifa.score !== 8'd1) begin n_bad++; $display("FAIL wrap_noscore: got %0d want 1", ifa.score); end
    endtask

    task automatic test_collide_restart();
        @(negedge clk) begin frame_tick = 1'b1; collide = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; collide = 1'b0; end
        n_cmp++; if (ifa.PipesPosition1 !== 16'd638 || ifa.PipesPosition2 !== 16'd318 || ifa.running !== 1'b0) begin n_bad++; $display("FAIL collide: got %0d/%0d run %0b want 638/318/0", ifa.PipesPosition1, ifa.PipesPosition2, ifa.running); end
        run_ticks(3);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd638 || ifa.PipesPosition2 !== 16'd318) begin n_bad++; $display("FAIL halt_hold: got %0d/%0d want 638/318", ifa.PipesPosition1, ifa.PipesPosition2); end
        @(negedge clk) begin restart = 1'b1; start = 1'b1; end
        @(negedge clk) begin restart = 1'b0; start = 1'b0; end
        n_cmp++; if (ifa.PipesPosition1 !== 16'd640 || ifa.PipesPosition2 !== 16'd960) begin n_bad++; $display("FAIL restart_pos: got %0d/%0d want 640/960", ifa.PipesPosition1, ifa.PipesPosition2); end
        n_cmp++; if (ifa.score !== 8'd0 || ifa.running !== 1'b0 || ifa.GapY1 !== 10'd80) begin n_bad++; $display("FAIL restart_flags: got score %0d run %0b gap %0d want 0/0/80", ifa.score, ifa.running, ifa.GapY1); end
        run_ticks(2);
        n_cmp++; if (ifa.PipesPosition1 !== 16'd640) begin n_bad++; $display("FAIL restart_idle: got %0d want 640", ifa.PipesPosition1); end
    endtask

    task automatic test_saturate();
        int k;
        int crossings;
        logic [15:0] p1_old;
        logic [15:0] p2_old;
        pulse_start();
        frame_tick = 1'b1;
        k = 0;
        while (k < 45000 && ifa.score !== 8'd255) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== 40911) begin n_bad++; $display("FAIL sat_ticks: got %0d want 40911", k); end
        n_cmp++; if (ifa.score_pulse !== 1'b1) begin n_bad++; $display("FAIL sat_last_pulse: got %0b want 1", ifa.score_pulse); end
        crossings = 0;
        for (int c = 0; c < 400; c++) begin
            p1_old = ifa.PipesPosition1;
            p2_old = ifa.PipesPosition2;
            @(negedge clk);
            if (p1_old >= 16'd100 && ifa.PipesPosition1 < 16'd100) crossings++;
            if (p2_old >= 16'd100 && ifa.PipesPosition2 < 16'd100) crossings++;
            n_cmp++; if (ifa.score !== 8'd255 || ifa.score_pulse !== 1'b0) begin n_bad++; $display("FAIL sat_hold: got score %0d pulse %0b want 255/0", ifa.score, ifa.score_pulse); end
        end
        n_cmp++; if (crossings < 2) begin n_bad++; $display("FAIL sat_crossed: got %0d crossings want >=2", crossings); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ifa.PipesPosition1 !== 16'd640 || ifa.PipesPosition2 !== 16'd960) begin n_bad++; $display("FAIL arst_pos: got %0d/%0d want 640/960", ifa.PipesPosition1, ifa.PipesPosition2); end
        n_cmp++; if (ifa.score !== 8'd0 || ifa.running !== 1'b0 || ifa.score_pulse !== 1'b0) begin n_bad++; $display("FAIL arst_flags: got score %0d run %0b pulse %0b want 0/0/0", ifa.score, ifa.running, ifa.score_pulse); end
        n_cmp++; if (ifa.GapY1 !== 10'd80 || ifa.GapY2 !== 10'd80) begin n_bad++; $display("FAIL arst_gap: got %0d/%0d want 80/80", ifa.GapY1, ifa.GapY2); end
        frame_tick = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_run10();
        test_score_cross();
        test_wrap();
        test_collide_restart();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
